// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
// Multi-cycle phase controller for the 8-bit ExceptioNull CPU. Steps one
// instruction at a time through FETCH .. PCUPD, skips the memory and
// writeback phases an instruction does not use, stalls on slow data
// memory with a bounded wait, and provides run / single-step / halt
// control plus debug counters for retired instructions and memory stalls.
//
// Every strobe, the phase code and 'halted' are registered from the
// next-state value, so they change only on the clock edge and always
// line up with the phase held in the state register.

module cpu_phase_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [7:0] MEM_TIMEOUT = 8'd16,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [3:0]       opcode,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             reg_w_en,
    input  logic             mem_ready,
    output logic             fetch,
    output logic             decode,
    output logic             reg_read,
    output logic             execute,
    output logic             access_mem,
    output logic             wb_resolve,
    output logic             writeback,
    output logic             update_pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    // Low three bits of each active phase are its externally visible code.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_REGREAD = 4'd2,
        S_EXECUTE = 4'd3,
        S_MEMACC  = 4'd4,
        S_WBRES   = 4'd5,
        S_WB      = 4'd6,
        S_PCUPD   = 4'd7,
        S_HALT    = 4'd8
    } phase_t;

    phase_t     cur_phase;
    phase_t     nxt_phase;
    logic       step_flag;
    logic [7:0] wait_cnt;

    logic       mem_access;
    logic       mem_stall;
    logic       mem_timeout;
    logic       stop_after_pc;

    assign mem_access    = mem_r_en | mem_w_en;
    assign mem_stall     = (cur_phase == S_MEMACC) && !mem_ready;
    // The wait that would be the MEM_TIMEOUT-th stalled cycle ends the access.
    assign mem_timeout   = mem_stall && (wait_cnt == MEM_TIMEOUT - 8'd1);
    assign stop_after_pc = (opcode == HALT_OPCODE) || halt_req || step_flag || !run;

    // Next-phase selection from the current phase and the qualifying inputs.
    always_comb begin
        // NOTE: default assignment first so no path leaves nxt_phase unassigned (no latch).
        nxt_phase = cur_phase;
        unique case (cur_phase)
            S_HALT: begin
                if (!mem_error && (run || step)) nxt_phase = S_FETCH;
            end
            S_FETCH:   nxt_phase = S_DECODE;
            S_DECODE:  nxt_phase = S_REGREAD;
            S_REGREAD: nxt_phase = S_EXECUTE;
            S_EXECUTE: begin
                if (mem_access)    nxt_phase = S_MEMACC;
                else if (reg_w_en) nxt_phase = S_WBRES;
                else               nxt_phase = S_PCUPD;
            end
            S_MEMACC: begin
                if (mem_ready)        nxt_phase = reg_w_en ? S_WBRES : S_PCUPD;
                else if (mem_timeout) nxt_phase = S_HALT;
            end
            S_WBRES: nxt_phase = S_WB;
            S_WB:    nxt_phase = S_PCUPD;
            S_PCUPD: nxt_phase = stop_after_pc ? S_HALT : S_FETCH;
            default: nxt_phase = S_HALT;
        endcase
    end

    // Phase register, registered strobes, step/wait bookkeeping and debug counters.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
        if (reset) begin
            cur_phase   <= S_HALT;
            step_flag   <= 1'b0;
            wait_cnt    <= 8'd0;
            fetch       <= 1'b0;
            decode      <= 1'b0;
            reg_read    <= 1'b0;
            execute     <= 1'b0;
            access_mem  <= 1'b0;
            wb_resolve  <= 1'b0;
            writeback   <= 1'b0;
            update_pc   <= 1'b0;
            state       <= 3'd0;
            halted      <= 1'b1;
            mem_error   <= 1'b0;
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            cur_phase  <= nxt_phase;

            fetch      <= (nxt_phase == S_FETCH);
            decode     <= (nxt_phase == S_DECODE);
            reg_read   <= (nxt_phase == S_REGREAD);
            execute    <= (nxt_phase == S_EXECUTE);
            access_mem <= (nxt_phase == S_MEMACC);
            wb_resolve <= (nxt_phase == S_WBRES);
            writeback  <= (nxt_phase == S_WB);
            update_pc  <= (nxt_phase == S_PCUPD);
            halted     <= (nxt_phase == S_HALT);
            state      <= (nxt_phase == S_HALT) ? 3'd0 : nxt_phase[2:0];

            // A step accepted from HALT limits the run to one instruction.
            if (cur_phase == S_HALT && step && !mem_error) step_flag <= 1'b1;
            else if (cur_phase == S_PCUPD)                 step_flag <= 1'b0;

            // Wait counter only lives across consecutive stalled MEMACC cycles.
            if (mem_stall && !mem_timeout) wait_cnt <= wait_cnt + 8'd1;
            else                           wait_cnt <= 8'd0;

            if (mem_stall)   stall_count <= stall_count + CNT_W'(1);
            if (mem_timeout) mem_error   <= 1'b1;

            if (cur_phase == S_PCUPD) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer. A behavioural model turns an
// instruction description (memory use, writeback, opcode, stall length and
// control levels) into the list of phases the CPU must walk through and the
// resulting counter values; observed phases are compared cycle by cycle.

module tb_cpu_phase_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic        reg_w_en = 1'b0;
    logic        mem_ready = 1'b0;
    logic        fetch, decode, reg_read, execute, access_mem;
    logic        wb_resolve, writeback, update_pc;
    logic [2:0]  state;
    logic        halted, mem_error;
    logic [15:0] instr_count, stall_count;

    cpu_phase_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
        .opcode(opcode), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .reg_w_en(reg_w_en), .mem_ready(mem_ready),
        .fetch(fetch), .decode(decode), .reg_read(reg_read), .execute(execute),
        .access_mem(access_mem), .wb_resolve(wb_resolve), .writeback(writeback),
        .update_pc(update_pc), .state(state), .halted(halted),
        .mem_error(mem_error), .instr_count(instr_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_instr = '0;
    logic [15:0] exp_stall = '0;
    logic        exp_err   = 1'b0;

    // Phase numbers: 0..7 = FETCH..PCUPD, 8 = HALT.
    int          exp_q[$];
    logic [3:0]  obs_q[$];
    logic [7:0]  obs_strb[$];

    function automatic logic [7:0] onehot(input int p);
        logic [7:0] r;
        r = (p >= 8) ? 8'h00 : (8'h01 << p);
        return r;
    endfunction

    // Behavioural model: phases visited by one instruction plus the phase after it.
    function automatic void model_instr(input bit mr, mw, rw, input logic [3:0] op,
                                        input int stalls, input bit run_l, hreq, stepping);
        exp_q.delete();
        for (int p = 0; p < 4; p++) exp_q.push_back(p);
        if (mr || mw) begin
            if (stalls >= TIMEOUT) begin
                repeat (TIMEOUT) exp_q.push_back(4);
                exp_stall = exp_stall + 16'(TIMEOUT);
                exp_err   = 1'b1;
                exp_q.push_back(8);
                return;
            end
            repeat (stalls + 1) exp_q.push_back(4);
            exp_stall = exp_stall + 16'(stalls);
        end
        if (rw) begin
            exp_q.push_back(5);
            exp_q.push_back(6);
        end
        exp_q.push_back(7);
        exp_instr = exp_instr + 16'd1;
        exp_q.push_back((op == 4'hF || hreq || stepping || !run_l) ? 8 : 0);
    endfunction

    // Drive one instruction starting at a negedge in FETCH; record what the DUT shows.
    task automatic exec_instr(input bit mr, mw, rw, input logic [3:0] op, input int stalls,
                              input bit run_l, hreq, stepping);
        int k;
        k = 0;
        model_instr(mr, mw, rw, op, stalls, run_l, hreq, stepping);
        obs_q.delete();
        obs_strb.delete();
        run = run_l;
        halt_req = hreq;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_q.push_back({halted, state});
            obs_strb.push_back({update_pc, writeback, wb_resolve, access_mem,
                                execute, reg_read, decode, fetch});
            if (i == exp_q.size() - 1) break;
            opcode = (exp_q[i] == 0) ? 4'($urandom) : op;
            if (exp_q[i] <= 1) begin
                mem_r_en = 1'($urandom);
                mem_w_en = 1'($urandom);
                reg_w_en = 1'($urandom);
            end else begin
                mem_r_en = mr;
                mem_w_en = mw;
                reg_w_en = rw;
            end
            if (exp_q[i] == 4) begin
                mem_ready = (k == stalls);
                k++;
            end else begin
                mem_ready = 1'($urandom);
            end
            step = ($urandom_range(5) == 0);
            @(negedge clk);
        end
        step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_instr = '0;
        exp_stall = '0;
        exp_err   = 1'b0;
    endtask

    // Leave HALT with a run level (stepping=0) or a step pulse (stepping=1).
    task automatic start_from_halt(input bit by_step, input bit run_l);
        run  = run_l;
        step = by_step;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({halted, state} !== 4'b1000 || {update_pc, writeback, wb_resolve, access_mem,
                execute, reg_read, decode, fetch} !== 8'h00 || mem_error !== 1'b0 ||
                instr_count !== 16'd0 || stall_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_state: halted=%b state=%0d err=%b ic=%0d sc=%0d, want 1 0 0 0 0",
                         halted, state, mem_error, instr_count, stall_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_writeback();
        start_from_halt(1'b0, 1'b1);
        exec_instr(1'b0, 1'b0, 1'b1, 4'h2, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                n_fail++;
                $display("FAIL alu_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                         i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
            end
        end
        n_checks++;
        if (instr_count !== exp_instr) begin
            n_fail++;
            $display("FAIL alu_instr_count: got %0d want %0d", instr_count, exp_instr);
        end
    endtask

    task automatic test_store_stall();
        exec_instr(1'b0, 1'b1, 1'b0, 4'h9, 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                n_fail++;
                $display("FAIL store_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                         i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
            end
        end
        n_checks++;
        if (stall_count !== exp_stall || instr_count !== exp_instr) begin
            n_fail++;
            $display("FAIL store_counts: got sc=%0d ic=%0d want sc=%0d ic=%0d",
                     stall_count, instr_count, exp_stall, exp_instr);
        end
    endtask

    task automatic test_halt_opcode();
        exec_instr(1'b0, 1'b0, 1'b1, 4'hF, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                n_fail++;
                $display("FAIL haltop_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                         i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
            end
        end
        n_checks++;
        if (instr_count !== exp_instr || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL haltop_end: got ic=%0d halted=%b want ic=%0d halted=1",
                     instr_count, halted, exp_instr);
        end
    endtask

    task automatic test_single_step();
        // Two plain steps, then a step while run is high: each retires exactly one.
        for (int s = 0; s < 3; s++) begin
            start_from_halt(1'b1, s == 2);
            exec_instr(1'b0, 1'b0, 1'b0, 4'h6, 0, s == 2, 1'b0, 1'b1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                    n_fail++;
                    $display("FAIL step%0d_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                             s, i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
                end
            end
            n_checks++;
            if (instr_count !== exp_instr) begin
                n_fail++;
                $display("FAIL step%0d_instr_count: got %0d want %0d", s, instr_count, exp_instr);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_random_run();
        bit in_halt;
        bit stepping;
        bit mr, mw, rw, hreq, run_l;
        logic [3:0] op;
        int stalls;
        in_halt = 1'b1;
        for (int n = 0; n < 40; n++) begin
            stepping = 1'b0;
            if (in_halt) begin
                stepping = ($urandom_range(1) == 0);
                start_from_halt(stepping, stepping ? 1'($urandom) : 1'b1);
            end
            case ($urandom_range(3))
                0:       begin mr = 1'b0; mw = 1'b0; rw = 1'($urandom); end
                1:       begin mr = 1'b1; mw = 1'b0; rw = 1'b1; end
                2:       begin mr = 1'b0; mw = 1'b1; rw = 1'b0; end
                default: begin mr = 1'b0; mw = 1'b0; rw = 1'b1; end
            endcase
            stalls = ($urandom_range(9) == 0) ? TIMEOUT - 1 : $urandom_range(4);
            op     = ($urandom_range(9) == 0) ? 4'hF : 4'($urandom_range(14));
            hreq   = ($urandom_range(7) == 0);
            run_l  = ($urandom_range(7) != 0);
            exec_instr(mr, mw, rw, op, stalls, run_l, hreq, stepping);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                    n_fail++;
                    $display("FAIL rand%0d_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                             n, i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
                end
            end
            n_checks++;
            if (instr_count !== exp_instr || stall_count !== exp_stall || mem_error !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_counts: got ic=%0d sc=%0d err=%b want ic=%0d sc=%0d err=0",
                         n, instr_count, stall_count, mem_error, exp_instr, exp_stall);
            end
            in_halt = (exp_q[exp_q.size() - 1] == 8);
        end
        if (!in_halt) begin
            run = 1'b0;
            exec_instr(1'b0, 1'b0, 1'b0, 4'h1, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_mem_timeout();
        start_from_halt(1'b0, 1'b1);
        exec_instr(1'b1, 1'b0, 1'b1, 4'h8, TIMEOUT + 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 4'(exp_q[i]) || obs_strb[i] !== onehot(exp_q[i])) begin
                n_fail++;
                $display("FAIL timeout_trace[%0d]: got code=%h strobes=%b, want code=%h strobes=%b",
                         i, obs_q[i], obs_strb[i], 4'(exp_q[i]), onehot(exp_q[i]));
            end
        end
        n_checks++;
        if (mem_error !== exp_err || instr_count !== exp_instr || stall_count !== exp_stall) begin
            n_fail++;
            $display("FAIL timeout_end: got err=%b ic=%0d sc=%0d want err=%b ic=%0d sc=%0d",
                     mem_error, instr_count, stall_count, exp_err, exp_instr, exp_stall);
        end
        // Neither run nor step may restart a CPU stopped by a memory error.
        run = 1'b1;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({halted, state} !== 4'b1000 || mem_error !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_sticky: got halted=%b state=%0d err=%b want 1 0 1",
                         halted, state, mem_error);
            end
            @(negedge clk);
        end
        do_reset();
        n_checks++;
        if (mem_error !== 1'b0 || instr_count !== 16'd0 || stall_count !== 16'd0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_reset: got err=%b ic=%0d sc=%0d halted=%b want 0 0 0 1",
                     mem_error, instr_count, stall_count, halted);
        end
    endtask

    task automatic test_reset_mid_access();
        start_from_halt(1'b0, 1'b1);
        exec_instr(1'b0, 1'b0, 1'b1, 4'h3, 0, 1'b1, 1'b0, 1'b0);
        opcode = 4'h8;
        mem_r_en = 1'b1;
        reg_w_en = 1'b1;
        mem_ready = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 3'd4 || access_mem !== 1'b1 || stall_count !== 16'd2) begin
            n_fail++;
            $display("FAIL midaccess_pre: got state=%0d access_mem=%b sc=%0d want 4 1 2",
                     state, access_mem, stall_count);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({halted, state} !== 4'b1000 || {update_pc, writeback, wb_resolve, access_mem,
            execute, reg_read, decode, fetch} !== 8'h00 || instr_count !== 16'd0 ||
            stall_count !== 16'd0 || mem_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midaccess_reset: got halted=%b state=%0d ic=%0d sc=%0d want 1 0 0 0",
                     halted, state, instr_count, stall_count);
        end
        reset = 1'b0;
        run = 1'b0;
        mem_r_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_store_stall();
        test_halt_opcode();
        test_single_step();
        test_random_run();
        test_mem_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
